// File: rtl/connect_four_pkg.sv
// Shared definitions for the Connect Four renderer: board geometry, cell codes,
// 8-bit RGB colour constants and the cell-to-bit-offset helper.
package connect_four_pkg;

   localparam int COLS = 7;
   localparam int ROWS = 6;

   // Two-bit cell codes; 2'b11 is unused and renders like an empty cell.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P1    = 2'b01,
      P2    = 2'b10
   } cell_e;

   // Colours packed as {r[2:0], g[2:0], b[1:0]}.
   localparam logic [7:0] C_BLACK  = 8'h00;
   localparam logic [7:0] C_BLUE   = 8'h03;
   localparam logic [7:0] C_RED    = 8'hE0;
   localparam logic [7:0] C_YELLOW = 8'hFC;

   // Bit offset of cell (c,r) inside the flat board vector, row 0 at the top.
   function automatic logic [6:0] cellOffset(input logic [2:0] c, input logic [2:0] r);
      return 7'((int'(r) * COLS + int'(c)) * 2);
   endfunction

endpackage

// File: rtl/connect_four_render_disc_mask.sv
// Registered disc test: is the in-cell offset (ox, oy) strictly inside a circle
// of radius RADIUS centred in the cell?
module disc_mask
#(
   parameter int CELL_LOG2 = 6,
   parameter int RADIUS    = 28
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CELL_LOG2-1:0] ox_i,
   input  logic [CELL_LOG2-1:0] oy_i,
   output logic                 disc_o
);

   localparam int SQ_W = 2 * CELL_LOG2;
   localparam logic [CELL_LOG2-1:0] HALF = CELL_LOG2'(1 << (CELL_LOG2 - 1));
   localparam logic [SQ_W-1:0] RSQ = SQ_W'(RADIUS * RADIUS);

   logic [CELL_LOG2-1:0] ax;
   logic [CELL_LOG2-1:0] ay;
   logic [SQ_W-1:0]      distSq;
   logic                 disc_d;
   logic                 disc_q;

   // Squaring the magnitude of the centred offset is the same as squaring the
   // signed value, and keeps the whole sum in unsigned arithmetic.
   always_comb begin
      ax     = (ox_i >= HALF) ? (ox_i - HALF) : (HALF - ox_i);
      ay     = (oy_i >= HALF) ? (oy_i - HALF) : (HALF - oy_i);
      distSq = SQ_W'(ax) * SQ_W'(ax) + SQ_W'(ay) * SQ_W'(ay);
      disc_d = (distSq < RSQ);
   end

   // The compare result is registered so it lines up with the second pipeline stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         disc_q <= 1'b0;
      end else begin
         disc_q <= disc_d;
      end
   end

   assign disc_o = disc_q;

endmodule

// File: rtl/connect_four_render.sv
// Two-stage pixel renderer for the Connect Four board that sits right after the
// VGA sync generator. Syncs are delayed to stay aligned with the RGB pipeline.
module connect_four_render
   import connect_four_pkg::*;
#(
   parameter int X0           = 96,
   parameter int Y0           = 64,
   parameter int CELL_LOG2    = 6,
   parameter int RADIUS       = 28,
   parameter int BLINK_FRAMES = 30
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        vga_h_sync_in,
   input  logic        vga_v_sync_in,
   input  logic        inDisplayArea,
   input  logic [9:0]  CounterX,
   input  logic [9:0]  CounterY,
   input  logic [83:0] board_state,
   input  logic [2:0]  cursor_col,
   input  logic        cur_player,
   output logic        vga_h_sync,
   output logic        vga_v_sync,
   output logic [2:0]  vga_r,
   output logic [2:0]  vga_g,
   output logic [1:0]  vga_b,
   output logic        frame_tick
);

   localparam int CELL    = 1 << CELL_LOG2;
   localparam int BOARD_W = COLS << CELL_LOG2;
   localparam int BOARD_H = ROWS << CELL_LOG2;
   localparam int CNT_W   = $clog2(BLINK_FRAMES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   // Sync delay line and frame bookkeeping.
   logic             hs1_q, hs2_q, vs1_q, vs2_q;
   logic             fall_d;
   logic             frameTick_q;
   logic [83:0]      snapshot_q;
   logic [CNT_W-1:0] frameCnt_q;
   logic             blink_q;

   // Stage 1 combinational terms.
   logic [10:0]          dx0, dy0, dyS;
   logic                 inBoard_d, inStrip_d, curHit_d;
   logic [2:0]           col_d, row_d;
   logic [CELL_LOG2-1:0] ox_d, oy_d;
   logic [83:0]          cellShift;
   logic [1:0]           cell_d;

   // Stage 1 and stage 2 registers.
   logic                 de1_q, inBoard1_q, inStrip1_q, curHit1_q, curPlayer1_q;
   logic [1:0]           cell1_q;
   logic [CELL_LOG2-1:0] ox1_q, oy1_q;
   logic                 de2_q, inBoard2_q, inStrip2_q, curHit2_q, curPlayer2_q;
   logic [1:0]           cell2_q;
   logic                 disc2;
   logic [7:0]           colour;

   // Two flops per sync so they leave with the pixel they belong to; a v-sync
   // fall is the live input low while the first delay stage still holds high.
   always_ff @(posedge clk) begin
      if (reset) begin
         hs1_q <= 1'b1;
         hs2_q <= 1'b1;
         vs1_q <= 1'b1;
         vs2_q <= 1'b1;
      end else begin
         hs1_q <= vga_h_sync_in;
         hs2_q <= hs1_q;
         vs1_q <= vga_v_sync_in;
         vs2_q <= vs1_q;
      end
   end

   assign fall_d = vs1_q & ~vga_v_sync_in;

   // Once per frame: pulse frame_tick, latch the board so a frame never shows
   // a half-applied move, and advance the cursor blink timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         frameTick_q <= 1'b0;
         snapshot_q  <= '0;
         frameCnt_q  <= '0;
         blink_q     <= 1'b1;
      end else begin
         frameTick_q <= fall_d;
         if (fall_d) begin
            snapshot_q <= board_state;
            if (frameCnt_q == CNT_LAST) begin
               frameCnt_q <= '0;
               blink_q    <= ~blink_q;
            end else begin
               frameCnt_q <= frameCnt_q + 1'b1;
            end
         end
      end
   end

   // Board-relative coordinates. The differences are kept unsigned so a
   // negative offset wraps to a huge value and fails the range compare, which
   // stops pixels left of or above the board from aliasing into a cell.
   always_comb begin
      dx0       = {1'b0, CounterX} - 11'(X0);
      dy0       = {1'b0, CounterY} - 11'(Y0);
      dyS       = {1'b0, CounterY} - 11'(Y0 - CELL);
      inBoard_d = (dx0 < 11'(BOARD_W)) && (dy0 < 11'(BOARD_H));
      inStrip_d = (dx0 < 11'(BOARD_W)) && (dyS < 11'(CELL));
      col_d     = dx0[CELL_LOG2 +: 3];
      row_d     = dy0[CELL_LOG2 +: 3];
      ox_d      = dx0[CELL_LOG2-1:0];
      oy_d      = inStrip_d ? dyS[CELL_LOG2-1:0] : dy0[CELL_LOG2-1:0];
      cellShift = '0;
      cell_d    = EMPTY;
      if (inBoard_d) begin
         cellShift = snapshot_q >> cellOffset(col_d, row_d);
         cell_d    = cellShift[1:0];
      end
      curHit_d  = inStrip_d && (cursor_col < 3'(COLS)) && (col_d == cursor_col);
   end

   // Stage 1 register: geometry flags, looked-up cell code and in-cell offsets.
   always_ff @(posedge clk) begin
      if (reset) begin
         de1_q        <= 1'b0;
         inBoard1_q   <= 1'b0;
         inStrip1_q   <= 1'b0;
         curHit1_q    <= 1'b0;
         curPlayer1_q <= 1'b0;
         cell1_q      <= EMPTY;
         ox1_q        <= '0;
         oy1_q        <= '0;
      end else begin
         de1_q        <= inDisplayArea;
         inBoard1_q   <= inBoard_d;
         inStrip1_q   <= inStrip_d;
         curHit1_q    <= curHit_d;
         curPlayer1_q <= cur_player;
         cell1_q      <= cell_d;
         ox1_q        <= ox_d;
         oy1_q        <= oy_d;
      end
   end

   disc_mask #(
      .CELL_LOG2 (CELL_LOG2),
      .RADIUS    (RADIUS)
   ) u_disc_mask (
      .clk    (clk),
      .reset  (reset),
      .ox_i   (ox1_q),
      .oy_i   (oy1_q),
      .disc_o (disc2)
   );

   // Stage 2 register: carry the flags forward to meet the registered disc bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         de2_q        <= 1'b0;
         inBoard2_q   <= 1'b0;
         inStrip2_q   <= 1'b0;
         curHit2_q    <= 1'b0;
         curPlayer2_q <= 1'b0;
         cell2_q      <= EMPTY;
      end else begin
         de2_q        <= de1_q;
         inBoard2_q   <= inBoard1_q;
         inStrip2_q   <= inStrip1_q;
         curHit2_q    <= curHit1_q;
         curPlayer2_q <= curPlayer1_q;
         cell2_q      <= cell1_q;
      end
   end

   // Colour priority: blanking, blue board frame, disc contents, then the cursor.
   always_comb begin
      colour = C_BLACK;
      if (!de2_q) begin
         colour = C_BLACK;
      end else if (inBoard2_q && !disc2) begin
         colour = C_BLUE;
      end else if (inBoard2_q) begin
         case (cell2_q)
            P1:      colour = C_RED;
            P2:      colour = C_YELLOW;
            default: colour = C_BLACK;
         endcase
      end else if (inStrip2_q && curHit2_q && disc2 && blink_q) begin
         colour = curPlayer2_q ? C_YELLOW : C_RED;
      end
   end

   assign {vga_r, vga_g, vga_b} = colour;
   assign vga_h_sync = hs2_q;
   assign vga_v_sync = vs2_q;
   assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_connect_four_render.sv
// Directed testbench for connect_four_render: reset, disc colours, board edges,
// cursor blink, frame snapshot behaviour and sync alignment.
module tb_connect_four_render;

   logic        clk;
   logic        reset;
   logic        vga_h_sync_in;
   logic        vga_v_sync_in;
   logic        inDisplayArea;
   logic [9:0]  CounterX;
   logic [9:0]  CounterY;
   logic [83:0] board_state;
   logic [2:0]  cursor_col;
   logic        cur_player;
   logic        vga_h_sync;
   logic        vga_v_sync;
   logic [2:0]  vga_r;
   logic [2:0]  vga_g;
   logic [1:0]  vga_b;
   logic        frame_tick;
   logic [7:0]  rgb;

   int   checks = 0;
   int   errors = 0;
   int   modelCnt = 0;
   logic modelBlink = 1'b1;
   logic prevH;

   assign rgb = {vga_r, vga_g, vga_b};

   connect_four_render dut (
      .clk           (clk),
      .reset         (reset),
      .vga_h_sync_in (vga_h_sync_in),
      .vga_v_sync_in (vga_v_sync_in),
      .inDisplayArea (inDisplayArea),
      .CounterX      (CounterX),
      .CounterY      (CounterY),
      .board_state   (board_state),
      .cursor_col    (cursor_col),
      .cur_player    (cur_player),
      .vga_h_sync    (vga_h_sync),
      .vga_v_sync    (vga_v_sync),
      .vga_r         (vga_r),
      .vga_g         (vga_g),
      .vga_b         (vga_b),
      .frame_tick    (frame_tick)
   );

   // 100 MHz-style free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one pixel on the falling edge, away from the sampling edge.
   task automatic applyStimulus(input int x, input int y, input logic de);
      @(negedge clk);
      CounterX      = 10'(x);
      CounterY      = 10'(y);
      inDisplayArea = de;
   endtask

   // Drive a pixel and check the colour two rising edges later.
   task automatic pixelCheck(input string tag, input int x, input int y, input logic de, input logic [7:0] expected);
      applyStimulus(x, y, de);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput(tag, rgb, expected);
   endtask

   // One v-sync pulse: frame_tick must be high for exactly one clock.
   task automatic frameEvent();
      @(negedge clk);
      vga_v_sync_in = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("frame_tick_high", {7'b0, frame_tick}, 8'h01);
      if (modelCnt == 29) begin
         modelCnt   = 0;
         modelBlink = ~modelBlink;
      end else begin
         modelCnt++;
      end
      @(posedge clk);
      #1;
      checkOutput("frame_tick_low", {7'b0, frame_tick}, 8'h00);
      @(negedge clk);
      vga_v_sync_in = 1'b1;
   endtask

   initial begin
      reset         = 1'b1;
      vga_h_sync_in = 1'b0;
      vga_v_sync_in = 1'b1;
      inDisplayArea = 1'b1;
      CounterX      = 10'd96;
      CounterY      = 10'd64;
      board_state   = '0;
      cursor_col    = 3'd7;
      cur_player    = 1'b0;

      // Reset held for 3 clocks with a blue pixel and low h-sync presented.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_rgb", rgb, 8'h00);
      checkOutput("reset_hsync", {7'b0, vga_h_sync}, 8'h01);
      checkOutput("reset_vsync", {7'b0, vga_v_sync}, 8'h01);
      checkOutput("reset_tick", {7'b0, frame_tick}, 8'h00);
      @(negedge clk);
      reset         = 1'b0;
      vga_h_sync_in = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("refill_1clk", rgb, 8'h00);
      @(posedge clk);
      #1;
      checkOutput("refill_2clk", rgb, 8'h03);

      // Snapshot cell (0,0) = player 1, disc centre is red.
      board_state = 84'h1;
      frameEvent();
      pixelCheck("p1_disc", 128, 96, 1'b1, 8'hE0);
      applyStimulus(96, 64, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("latency_hold", rgb, 8'hE0);
      @(posedge clk);
      #1;
      checkOutput("latency_new", rgb, 8'h03);
      board_state = 84'h0;
      frameEvent();
      pixelCheck("empty_disc", 128, 96, 1'b1, 8'h00);

      // Board boundaries and blanking.
      pixelCheck("corner_blue", 96, 64, 1'b1, 8'h03);
      pixelCheck("left_outside", 95, 64, 1'b1, 8'h00);
      pixelCheck("right_inside", 543, 100, 1'b1, 8'h03);
      pixelCheck("right_outside", 544, 100, 1'b1, 8'h00);
      pixelCheck("bottom_inside", 128, 447, 1'b1, 8'h03);
      pixelCheck("bottom_outside", 128, 448, 1'b1, 8'h00);
      pixelCheck("blanked", 128, 96, 1'b0, 8'h00);

      // Cursor strip above the board.
      cursor_col = 3'd3;
      cur_player = 1'b1;
      pixelCheck("cursor_p2", 320, 32, 1'b1, modelBlink ? 8'hFC : 8'h00);
      cur_player = 1'b0;
      pixelCheck("cursor_p1", 320, 32, 1'b1, modelBlink ? 8'hE0 : 8'h00);
      pixelCheck("cursor_other_col", 256, 32, 1'b1, 8'h00);
      cursor_col = 3'd7;
      pixelCheck("cursor_none", 320, 32, 1'b1, 8'h00);
      cursor_col = 3'd3;
      cur_player = 1'b1;
      for (int i = 0; i < 30; i++) begin
         frameEvent();
      end
      pixelCheck("cursor_blink_off", 320, 32, 1'b1, modelBlink ? 8'hFC : 8'h00);

      // Mid-frame board change is invisible until the next frame.
      board_state = {2'b01, 80'h0, 2'b10};
      pixelCheck("snap_hold_00", 128, 96, 1'b1, 8'h00);
      pixelCheck("snap_hold_65", 512, 416, 1'b1, 8'h00);
      frameEvent();
      pixelCheck("snap_new_00", 128, 96, 1'b1, 8'hFC);
      pixelCheck("snap_new_65", 512, 416, 1'b1, 8'hE0);
      pixelCheck("snap_new_10", 192, 96, 1'b1, 8'h00);

      // Random h-sync pattern must come out one registered step behind each drive,
      // i.e. two flops after the input.
      prevH = vga_h_sync_in;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         vga_h_sync_in = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         checkOutput("hsync_delay", {7'b0, vga_h_sync}, {7'b0, prevH});
         checkOutput("vsync_idle", {7'b0, vga_v_sync}, 8'h01);
         prevH = vga_h_sync_in;
      end

      // Reset asserted mid-line clears outputs on the next edge.
      applyStimulus(128, 96, 1'b1);
      vga_h_sync_in = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("pre_reset_rgb", rgb, 8'hFC);
      checkOutput("pre_reset_hsync", {7'b0, vga_h_sync}, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midline_reset_rgb", rgb, 8'h00);
      checkOutput("midline_reset_hsync", {7'b0, vga_h_sync}, 8'h01);
      checkOutput("midline_reset_vsync", {7'b0, vga_v_sync}, 8'h01);
      @(negedge clk);
      reset = 1'b0;
      vga_h_sync_in = 1'b1;
      pixelCheck("post_reset_snapshot", 128, 96, 1'b1, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/connect_four_render.md
Name: connect_four_render

Overview:
Pixel renderer directly downstream of the VGA `sync` stage. It consumes the sync stage's outputs: raw h/v sync, `inDisplayArea`, `CounterX` and `CounterY`. From these it produces 8-bit RGB for the 7x6 Connect Four board, discs and a blinking drop cursor. It delays the syncs to match its 2-clock pipeline, and snapshots the game board once per frame to avoid tearing.

Parameters:
- X0, 96: board left edge, pixels.
- Y0, 64: board top edge, pixels. The cursor strip occupies Y0-64 .. Y0-1.
- CELL_LOG2, 6: cell size is 2^CELL_LOG2 = 64 px square.
- RADIUS, 28: disc radius, pixels.
- BLINK_FRAMES, 30: frames per cursor blink half-period.

Ports:
- clk, in, 1: pixel-domain clock, same as the `sync` stage.
- reset, in, 1: synchronous, active-high.
- vga_h_sync_in, in, 1: from `sync`, active-low.
- vga_v_sync_in, in, 1: from `sync`, active-low.
- inDisplayArea, in, 1: from `sync`.
- CounterX, in, 10: from `sync`.
- CounterY, in, 10: from `sync`.
- board_state, in, 84: 2 bits per cell. Cell (c,r) is at bits [2*(r*7+c)+1 : 2*(r*7+c)], with row 0 at the top. 00 = empty, 01 = player 1, 10 = player 2, 11 = empty.
- cursor_col, in, 3: column 0..6; values 7 and above mean no cursor.
- cur_player, in, 1: 0 = player 1, 1 = player 2.
- vga_h_sync, out, 1: h sync delayed 2 clocks.
- vga_v_sync, out, 1: v sync delayed 2 clocks.
- vga_r, out, 3.
- vga_g, out, 3.
- vga_b, out, 2.
- frame_tick, out, 1: one-clock pulse on the v-sync falling edge.

Behaviour:
Clocking and reset:
- Single clock `clk`; reset is synchronous, active-high.
- On reset:
  - RGB = 0.
  - vga_h_sync = vga_v_sync = 1 (inactive).
  - Sync delay registers = 1.
  - frame_tick = 0.
  - Board snapshot = all 0 (empty).
  - Frame counter = 0.
  - blink = 1.
  - Pipeline valid/flags = 0.
- Reset asserted mid-frame takes effect on the next edge. Output is black until the pipeline refills, 2 clocks after release.

Frame event:
- Register vga_v_sync_in. Fall = previous 1 and current 0; frame_tick pulses for one clock on that cycle.
- On frame_tick:
  - Load the snapshot from board_state.
  - Increment the frame counter. At BLINK_FRAMES-1 the counter wraps to 0 and blink toggles.
- cursor_col and cur_player are sampled live in stage 1 and are not snapshotted.

Stage 1 (registered):
- dx0 = CounterX - X0 and dy0 = CounterY - Y0, computed 11-bit signed.
- in_board = dx0 in [0, 447] and dy0 in [0, 383].
- in_strip = dx0 in [0, 447] and CounterY in [Y0-64, Y0-1].
- Cell indices: col = dx0 >> CELL_LOG2 and row = dy0 >> CELL_LOG2.
- In-cell offsets: ox = low 6 bits of dx0; oy = low 6 bits of dy0. For the strip, oy is taken from CounterY - (Y0-64).
- inDisplayArea is registered alongside.

Stage 2 (registered):
- Disc test: sx = ox - 32 and sy = oy - 32 (signed, range -32..31). disc = sx*sx + sy*sy < RADIUS*RADIUS, evaluated at 12-bit unsigned width.
- Colour priority, first match wins:
  1. Not in display area → 8'h00.
  2. in_board and not disc → blue, 8'h03.
  3. in_board and disc → colour of the snapshot cell code: empty → 8'h00, player 1 → red 8'hE0, player 2 → yellow 8'hFC.
  4. in_strip, col == cursor_col, cursor_col < 7, disc and blink=1 → colour of cur_player.
  5. Otherwise → 8'h00.
- RGB packing: {vga_r, vga_g, vga_b} = colour[7:5], [4:2], [1:0].

Latency:
- RGB and both syncs lag their inputs by exactly 2 clocks, always in alignment.

Boundaries:
- X=X0+447 is inside the board; X=X0+448 is outside.
- Negative dx0 or dy0 is outside; no wrap into cells.
- board_state changes mid-frame are not visible until the next frame_tick.

Decomposition:
- Shared package `connect_four_pkg`:
  - Constants: COLS=7, ROWS=6.
  - Cell codes: EMPTY, P1, P2.
  - Colour constants: C_BLACK, C_BLUE, C_RED, C_YELLOW.
  - Cell-index function (c,r) → bit offset.
- One natural sub-module `disc_mask`: registered squared-distance compare of (ox, oy) against RADIUS.

Test Plan:
1. Reset 3 clocks, then release → RGB=0, syncs=1, frame_tick=0. Output remains 00 until pipeline data arrives 2 clocks after release.
2. Snapshot cell (0,0)=01 via a v-sync fall. Drive X=128, Y=96, inDisplayArea=1 → 2 clocks later RGB=8'hE0. Same pixel with cell=00 → 8'h00.
3. Drive X=96, Y=64 (disc corner) → 8'h03. X=95 → 8'h00. X=543, Y=100 → 8'h03. X=544 → 8'h00. inDisplayArea=0 at X=128, Y=96 → 8'h00.
4. Drive cursor_col=3, cur_player=1, X=320, Y=32, blink=1 → 8'hFC. After 30 frame_ticks → 8'h00. cursor_col=7 → 8'h00.
5. Change board_state mid-frame → pixel colour unchanged until the next vga_v_sync_in fall, then updated. frame_tick is exactly one clock wide.
6. Toggle vga_h_sync_in with a random pattern → vga_h_sync equals the input delayed 2 clocks. Assert reset mid-line → syncs=1 and RGB=0 on the next clock.
